// File: rtl/nrzi_rx_decoder.sv
// USB full-speed receive path: NRZI decode, SYNC detect, bit-unstuffing and
// LSB-first byte assembly, with EOP detection and protocol-fault reporting.
//
// state | meaning
// IDLE  | bus idle, waiting for the first K of a SYNC
// SYNC  | counting decoded 0s until the SYNC-terminating 1
// DATA  | packet body: unstuffing and byte assembly
// EOP   | SE0 seen, waiting for the closing J
// ABORT | after a fault, waiting for SE0 then J, or 8 consecutive J strobes
module nrzi_rx_decoder #(
    parameter int SYNC_MIN_ZEROS = 5
) (
    input  logic       useClk,
    input  logic       rstN,
    input  logic       checkData,
    input  logic       dp,
    input  logic       dn,
    output logic [7:0] rxData,
    output logic       rxValid,
    output logic       rxActive,
    output logic       rxEop,
    output logic       rxError
);

    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ABORT} rxState_t;

    localparam logic [2:0] SYNC_MIN = 3'(SYNC_MIN_ZEROS);

    rxState_t   state;
    logic       prevIsK;
    logic [2:0] zeroCnt;
    logic [2:0] onesCnt;
    logic [3:0] bitCnt;
    logic [7:0] shiftReg;
    logic       sawSe0;

    logic       isJ, isK, isSe0, isSe1, isJk;
    logic       lineBit;
    logic [7:0] shiftNext;
    logic       symError;

    assign isJ       = dp & ~dn;
    assign isK       = ~dp & dn;
    assign isSe0     = ~dp & ~dn;
    assign isSe1     = dp & dn;
    assign isJk      = isJ | isK;
    assign lineBit   = isK ? prevIsK : ~prevIsK;
    assign shiftNext = {lineBit, shiftReg[7:1]};

    always_comb begin
        symError = 1'b0;
        case (state)
            DATA:    symError = isSe1 | (isJk & lineBit & (onesCnt == 3'd6));
            EOP:     symError = isK | isSe1;
            default: symError = 1'b0;
        endcase
    end

    always_ff @(posedge useClk) begin
        if (!rstN) begin
            state    <= IDLE;
            prevIsK  <= 1'b0;
            zeroCnt  <= 3'd0;
            onesCnt  <= 3'd0;
            bitCnt   <= 4'd0;
            shiftReg <= 8'd0;
            sawSe0   <= 1'b0;
            rxData   <= 8'd0;
            rxValid  <= 1'b0;
            rxActive <= 1'b0;
            rxEop    <= 1'b0;
            rxError  <= 1'b0;
        end else begin
            rxValid <= 1'b0;
            rxEop   <= 1'b0;
            rxError <= 1'b0;
            if (checkData) begin
                if (isJk) prevIsK <= isK;
                if (symError) begin
                    rxError  <= 1'b1;
                    rxActive <= 1'b0;
                    state    <= ABORT;
                    sawSe0   <= 1'b0;
                    bitCnt   <= 4'd0;
                    onesCnt  <= 3'd0;
                end else begin
                    case (state)
                        IDLE: begin
                            zeroCnt <= 3'd0;
                            if (isK) begin
                                state   <= SYNC;
                                zeroCnt <= 3'd1;
                            end
                        end
                        SYNC: begin
                            if (!isJk) begin
                                state <= IDLE;
                            end else if (!lineBit) begin
                                if (zeroCnt != 3'd7) zeroCnt <= zeroCnt + 3'd1;
                            end else if (zeroCnt >= SYNC_MIN) begin
                                state    <= DATA;
                                rxActive <= 1'b1;
                                onesCnt  <= 3'd1;
                                bitCnt   <= 4'd0;
                            end else begin
                                state <= IDLE;
                            end
                        end
                        DATA: begin
                            if (isSe0) begin
                                state <= EOP;
                            end else if (!lineBit && onesCnt == 3'd6) begin
                                onesCnt <= 3'd0;
                            end else begin
                                onesCnt  <= lineBit ? onesCnt + 3'd1 : 3'd0;
                                shiftReg <= shiftNext;
                                if (bitCnt == 4'd7) begin
                                    rxData  <= shiftNext;
                                    rxValid <= 1'b1;
                                    bitCnt  <= 4'd0;
                                end else begin
                                    bitCnt <= bitCnt + 4'd1;
                                end
                            end
                        end
                        EOP: begin
                            if (isJ) begin
                                // a pending stuffed bit means the packet was cut short
                                if (bitCnt == 4'd0 && onesCnt != 3'd6) rxEop <= 1'b1;
                                else rxError <= 1'b1;
                                rxActive <= 1'b0;
                                state    <= IDLE;
                            end
                        end
                        ABORT: begin
                            if (isSe0) begin
                                sawSe0 <= 1'b1;
                                bitCnt <= 4'd0;
                            end else if (isJ) begin
                                if (sawSe0 || bitCnt == 4'd7) begin
                                    state  <= IDLE;
                                    sawSe0 <= 1'b0;
                                    bitCnt <= 4'd0;
                                end else begin
                                    bitCnt <= bitCnt + 4'd1;
                                end
                            end else begin
                                sawSe0 <= 1'b0;
                                bitCnt <= 4'd0;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule
